// File: rtl/iwrr_pkg.sv
// Shared helpers for the IWRR arbiter: index width, effective weight and round-end test.
// The round-end function is also used by the granter's bench model, so it stays tool-neutral.
package iwrr_pkg;

  localparam int IWRR_MAX_REQ = 32;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned effective_weight(input int unsigned w);
    return (w == 0) ? 1 : w;
  endfunction

  // True when every requesting port has completed and at least one port has completed.
  function automatic logic round_end(input logic [IWRR_MAX_REQ-1:0] request,
                                     input logic [IWRR_MAX_REQ-1:0] cmp);
    return (|cmp) && ((request & ~cmp) == '0);
  endfunction

endpackage

// File: rtl/iwrr_credit_counter.sv
// Credit counter for one requester: latched weight, saturating grant count, completed flag.
module iwrr_credit_counter
  import iwrr_pkg::*;
#(
  parameter int P_WEIGHT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fire,
  input  logic                  clear,
  input  logic                  load,
  input  logic [P_WEIGHT_W-1:0] weight,
  output logic                  cmp
);

  logic [P_WEIGHT_W-1:0] cnt;
  logic [P_WEIGHT_W-1:0] wq;
  logic [P_WEIGHT_W-1:0] eff_w;
  logic [P_WEIGHT_W-1:0] cnt_base;
  logic [P_WEIGHT_W-1:0] cnt_next;
  logic                  cmp_next;

  // A fire in a load/clear cycle belongs to the new round, so it is judged against the new weight.
  always_comb begin
    eff_w    = P_WEIGHT_W'(effective_weight(32'(load ? weight : wq)));
    cnt_base = clear ? '0 : cnt;
    cnt_next = cnt_base;
    if (fire && (cnt_base < eff_w)) begin
      cnt_next = cnt_base + P_WEIGHT_W'(1);
    end
    cmp_next = (cmp & ~clear) | (cnt_next == eff_w);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      wq  <= P_WEIGHT_W'(1);
      cmp <= 1'b0;
    end else begin
      cnt <= cnt_next;
      cmp <= cmp_next;
      if (load) begin
        wq <= weight;
      end
    end
  end

endmodule

// File: rtl/iwrr_credit_tracker.sv
// Weight-credit bookkeeping for the IWRR arbiter: per-requester credit counters,
// round-end detection, rotating highest-priority index and round_done pulse.
module iwrr_credit_tracker
  import iwrr_pkg::*;
#(
  parameter int P_REQUESTER_NUM = 3,
  parameter int P_WEIGHT_W      = 4,
  parameter int P_IDX_W         = idx_width(P_REQUESTER_NUM)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [P_REQUESTER_NUM-1:0]            request,
  input  logic [P_REQUESTER_NUM-1:0]            grant,
  input  logic                                  grant_fire,
  input  logic [P_REQUESTER_NUM*P_WEIGHT_W-1:0] weight_cfg,
  output logic [P_REQUESTER_NUM-1:0]            request_weight_completed,
  output logic [P_IDX_W-1:0]                    highest_prior_idx,
  output logic                                  round_done
);

  localparam logic [P_IDX_W-1:0] LAST_IDX = P_IDX_W'(P_REQUESTER_NUM - 1);

  logic                       init_q;
  logic                       rollover;
  logic [P_REQUESTER_NUM-1:0] cmp;

  // The init cycle only loads weights; cmp is all-zero then, so no rollover can start.
  always_comb begin
    rollover = !init_q && round_end(IWRR_MAX_REQ'(request), IWRR_MAX_REQ'(cmp));
  end

  for (genvar i = 0; i < P_REQUESTER_NUM; i++) begin : g_req
    iwrr_credit_counter #(
      .P_WEIGHT_W(P_WEIGHT_W)
    ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .fire   (grant_fire & grant[i]),
      .clear  (rollover),
      .load   (rollover | init_q),
      .weight (weight_cfg[i*P_WEIGHT_W +: P_WEIGHT_W]),
      .cmp    (cmp[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_q            <= 1'b1;
      highest_prior_idx <= '0;
      round_done        <= 1'b0;
    end else begin
      init_q     <= 1'b0;
      round_done <= rollover;
      if (rollover) begin
        highest_prior_idx <= (highest_prior_idx == LAST_IDX) ? '0
                                                             : highest_prior_idx + P_IDX_W'(1);
      end
    end
  end

  assign request_weight_completed = cmp;

endmodule

// File: doc/iwrr_credit_tracker.md
# iwrr_credit_tracker

Per-requester weight-credit bookkeeping for the interleaved weighted round-robin (IWRR) arbiter. It counts accepted grants per requester against programmable weights and drives the `request_weight_completed` vector consumed by the priority granter. It also detects round completion and rotates the highest-priority index fed back to the granter. It sits between the granter's one-hot grant output and the downstream accept handshake.

## Interface
- `P_REQUESTER_NUM`, 3: number of requesters (≥2).
- `P_WEIGHT_W`, 4: weight and credit-counter width.
- `P_IDX_W`, `$clog2(P_REQUESTER_NUM)`: width of the priority index.

- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `request` in N: raw request vector (same one the granter sees).
- `grant` in N: one-hot grant from the granter.
- `grant_fire` in 1: the granted transfer was accepted this cycle.
- `weight_cfg` in N*`P_WEIGHT_W`: weight of requester i at bits [i*W +: W].
- `request_weight_completed` out N: registered; bit i = requester i exhausted its credit this round.
- `highest_prior_idx` out `P_IDX_W`: registered rotating highest-priority index.
- `round_done` out 1: registered one-cycle pulse at round rollover.

## Operation
- Per requester: credit counter `cnt[i]` (W bits), latched weight `wq[i]`, completed flag `cmp[i]`.
- Effective weight: `wq[i]==0` is treated as 1.
- Fire: on `grant_fire` with `grant[i]=1`:
  - `cnt[i]` increments, saturating at effective weight.
  - `cmp[i]` sets when the new count equals the effective weight.
- Exception-path grants (granter serving an already-completed requester that is the sole requester) are counted but saturate; `cmp` stays 1.
- `grant_fire` with `grant==0` is ignored. Multi-hot `grant` is illegal; the bench asserts against it.
- Round-end condition, evaluated on registered state each cycle: every `i` with `request[i]=1` has `cmp[i]=1`, AND `|cmp` = 1. With no requests and any `cmp` set, the condition is true.
- Rollover at the next edge after the condition holds:
  - all `cnt`/`cmp` cleared;
  - `wq` reloaded from `weight_cfg`;
  - `highest_prior_idx` ← (idx+1) mod N, wrapping N-1→0;
  - `round_done` pulses.
- Fire coinciding with the rollover cycle: counted as the first credit of the new round (`cnt`=1; `cmp` set if effective weight is 1). Rollover clear never drops it.
- `weight_cfg` changes mid-round have no effect until the next rollover.
- Weight load after reset: `wq` resets to 1. A one-shot `init` flag loads `weight_cfg` in the first cycle after `rst` deasserts, with no rollover, pulse or index change.

## Timing
- Reset values: `request_weight_completed`=0, `highest_prior_idx`=0, `round_done`=0, `cnt`=0, `wq`=1, `init`=1.
- Fire → `cmp` visible: 1 cycle.
- Last completing fire → `round_done`: 2 cycles (cmp at +1, rollover at +2). `cmp` clears in the same cycle `round_done` is high.
- `round_done` is exactly one cycle wide. Back-to-back rounds are possible (weight 1, continuous fires).
- Reset asserted mid-round: all state returns to reset values immediately and asynchronously. No pulse is generated.

## Structure
- Shared package `iwrr_pkg`:
  - index-width helper function;
  - `effective_weight` function (0→1);
  - round-end condition function, reused by the granter bench model.
- One sub-module `iwrr_credit_counter`: `cnt`/`wq`/`cmp` for a single requester, with inputs `fire`, `clear`, `load`, `weight`. Instantiated N times by generate.
- Top level holds `init`, the round-end detector, the index rotator and `round_done`.

## Test plan
All scenarios use N=3, W=4, `weight_cfg`={2,1,3} for requesters 0,1,2.

- **Reset and load:** assert `rst` → all outputs 0 and idx 0. Deassert → `wq` loaded; `round_done` stays 0.
- **Full round:** `request`=111; fires granted 0,0,1,2,2,2.
  - `cmp` = 001 after fire 2, 011 after fire 3, 111 after fire 6.
  - `round_done`=1 two cycles after fire 6; `cmp`=000; idx=1.
- **Partial requesters:** `request`=001, two fires on 0 → `cmp`=001, then rollover and `round_done`. Repeat three times → idx walks 1,2,0 (wrap).
- **Coincident fire:** fire on requester 1 in the rollover cycle → after the edge `cmp`=010, `cnt[1]`=1, no credit lost.
- **Zero weight and config change:** `weight_cfg` {0,1,3} applied mid-round → ignored until rollover. Afterward a single fire on 0 sets `cmp[0]`.
- **Reset mid-round:** `cmp`=001 and idx=2, pulse `rst` → `cmp`=0 and idx=0 within the same cycle, no `round_done`.
